rgb565_gray_arbiter: RTL

Shares a single RGB565-to-grayscale conversion datapath between two requesters: the CPU custom-instruction port and a streaming pixel port fed by the camera path. Each conversion turns four byte-swapped RGB565 pixels into four 8-bit gray bytes. The block provides round-robin arbitration, a registered result stage with stream backpressure, and per-requester conversion counters readable through a second custom instruction. It sits between the CPU CI bus and the camera-to-memory pixel pipeline.

---
 rtl/rgb565_gray_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/rgb565_gray_arbiter.sv
// rgb565_gray_arbiter
// One RGB565 (byte-swapped) to 8-bit grayscale datapath shared by the CPU
// custom-instruction port and the camera stream port. A round-robin arbiter
// hands out one datapath slot per cycle. CI results come back as a one-cycle
// ciDone pulse; stream results sit in a registered output stage that holds
// under backpressure. Per-requester conversion counters are read (and
// optionally cleared) through a second custom instruction.

module rgb565_gray_arbiter #(
  parameter logic [7:0] customInstructionId = 8'd13,
  parameter logic [7:0] statusInstructionId = 8'd14
) (
  input  logic        clock,
  input  logic        reset,
  // CPU custom-instruction port
  input  logic        ciStart,
  input  logic [7:0]  ciN,
  input  logic [31:0] ciValueA,
  input  logic [31:0] ciValueB,
  output logic        ciDone,
  output logic [31:0] ciResult,
  // camera stream input
  input  logic        streamValid,
  input  logic [63:0] streamPixels,
  output logic        streamReady,
  // gray stream output
  output logic        grayValid,
  output logic [31:0] grayData,
  input  logic        grayReady
);

  // Converts one byte-swapped RGB565 pixel to gray.
  // Layout: [15:13]=g[2:0], [12:8]=b, [7:3]=r, [2:0]=g[5:3].
  // With 8-bit expanded channels the weighted sum peaks at 64220, so a
  // 16-bit unsigned accumulator never overflows and the top byte is the gray.
  function automatic logic [7:0] gray_pix(input logic [15:0] pix);
    logic [4:0]  r;
    logic [4:0]  b;
    logic [5:0]  g;
    logic [15:0] acc;
    r   = pix[7:3];
    b   = pix[12:8];
    g   = {pix[2:0], pix[15:13]};
    acc = 16'd54  * {8'd0, r, 3'b000}
        + 16'd183 * {8'd0, g, 2'b00}
        + 16'd19  * {8'd0, b, 3'b000};
    return acc[15:8];
  endfunction

  // Four lanes in parallel; lane k takes pixels [16k+15:16k].
  function automatic logic [31:0] gray_quad(input logic [63:0] pix);
    return {gray_pix(pix[63:48]), gray_pix(pix[47:32]),
            gray_pix(pix[31:16]), gray_pix(pix[15:0])};
  endfunction

  // State registers
  logic        ci_pending_q,    ci_pending_d;
  logic [63:0] ci_pix_q,        ci_pix_d;
  logic        last_grant_ci_q, last_grant_ci_d;
  logic        ci_done_q,       ci_done_d;
  logic [31:0] ci_result_q,     ci_result_d;
  logic        gray_valid_q,    gray_valid_d;
  logic [31:0] gray_data_q,     gray_data_d;
  logic [15:0] ci_count_q,      ci_count_d;
  logic [15:0] stream_count_q,  stream_count_d;

  // Decoded requests and arbitration results
  logic        ci_cmd;
  logic        status_cmd;
  logic        count_clear;
  logic        out_free;
  logic        ci_req;
  logic        st_req;
  logic        grant_ci;
  logic        grant_st;
  logic [63:0] dp_in;
  logic [31:0] dp_out;

  // CI decode: a new conversion or status read is only taken while no
  // conversion is pending, so a status answer can never collide with a
  // conversion answer on ciResult.
  always_comb begin
    ci_cmd      = ciStart && (ciN == customInstructionId) && !ci_pending_q;
    status_cmd  = ciStart && (ciN == statusInstructionId) && !ci_pending_q;
    count_clear = status_cmd && ciValueA[0];
  end

  // Round-robin arbiter: a lone requester wins; on a tie the requester that
  // did not get the previous slot wins.
  always_comb begin
    out_free = !gray_valid_q || grayReady;
    ci_req   = ci_pending_q;
    st_req   = streamValid && out_free;
    grant_ci = ci_req && (!st_req || !last_grant_ci_q);
    grant_st = st_req && (!ci_req ||  last_grant_ci_q);
  end

  // Shared datapath: the granted requester's quad goes through the single
  // converter instance.
  always_comb begin
    dp_in  = grant_ci ? ci_pix_q : streamPixels;
    dp_out = gray_quad(dp_in);
  end

  // CI side next state: pending capture, grant bookkeeping and the
  // one-cycle result (zero whenever ciDone is low).
  always_comb begin
    ci_pending_d    = ci_pending_q;
    ci_pix_d        = ci_pix_q;
    last_grant_ci_d = last_grant_ci_q;
    ci_done_d       = 1'b0;
    ci_result_d     = 32'd0;
    if (ci_cmd) begin
      ci_pending_d = 1'b1;
      ci_pix_d     = {ciValueB, ciValueA};
    end
    if (grant_ci) begin
      ci_pending_d    = 1'b0;
      last_grant_ci_d = 1'b1;
      ci_done_d       = 1'b1;
      ci_result_d     = dp_out;
    end else if (grant_st) begin
      last_grant_ci_d = 1'b0;
    end
    if (status_cmd) begin
      ci_done_d   = 1'b1;
      ci_result_d = {stream_count_q, ci_count_q};
    end
  end

  // Stream output stage: load on a stream grant, otherwise drop valid once
  // the consumer takes the word; data is held stable while stalled.
  always_comb begin
    gray_valid_d = gray_valid_q;
    gray_data_d  = gray_data_q;
    if (grant_st) begin
      gray_valid_d = 1'b1;
      gray_data_d  = dp_out;
    end else if (grayReady) begin
      gray_valid_d = 1'b0;
    end
  end

  // Conversion counters: 16-bit wrapping; a clear wins over a coincident
  // increment.
  always_comb begin
    ci_count_d     = ci_count_q     + {15'd0, grant_ci};
    stream_count_d = stream_count_q + {15'd0, grant_st};
    if (count_clear) begin
      ci_count_d     = 16'd0;
      stream_count_d = 16'd0;
    end
  end

  // All state registers; reset discards any pending CI and held stream word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ci_pending_q    <= 1'b0;
      ci_pix_q        <= 64'd0;
      last_grant_ci_q <= 1'b0;
      ci_done_q       <= 1'b0;
      ci_result_q     <= 32'd0;
      gray_valid_q    <= 1'b0;
      gray_data_q     <= 32'd0;
      ci_count_q      <= 16'd0;
      stream_count_q  <= 16'd0;
    end else begin
      ci_pending_q    <= ci_pending_d;
      ci_pix_q        <= ci_pix_d;
      last_grant_ci_q <= last_grant_ci_d;
      ci_done_q       <= ci_done_d;
      ci_result_q     <= ci_result_d;
      gray_valid_q    <= gray_valid_d;
      gray_data_q     <= gray_data_d;
      ci_count_q      <= ci_count_d;
      stream_count_q  <= stream_count_d;
    end
  end

  // Output mapping
  always_comb begin
    ciDone      = ci_done_q;
    ciResult    = ci_result_q;
    streamReady = grant_st;
    grayValid   = gray_valid_q;
    grayData    = gray_data_q;
  end

endmodule
